// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep checker.
// With TT_SWEEP_ERRCNT_EN defined, the checker also exports a mismatch count.
package tt_sweep_pkg;

    localparam int VEC_W   = 3;
    localparam int NUM_VEC = 8;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic logic [3:0] popcount8(input logic [NUM_VEC-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_VEC; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Clearable settle counter; expired marks the final settle cycle of a vector.
module tt_settle_timer
    import tt_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted while counting the last of SETTLE_CYCLES settle cycles.
    assign expired = en && (count_q == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/tt_sweep_checker.sv
// Walks {a,b,c} through all 8 vectors, samples y_in after settling and compares
// it with a latched truth table. TT_SWEEP_ERRCNT_EN adds the err_cnt output.
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] exp_tt,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] cap_tt,
`ifdef TT_SWEEP_ERRCNT_EN
    output logic [7:0] mismatch,
    output logic [3:0] err_cnt
`else
    output logic [7:0] mismatch
`endif
);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   idx_q, idx_d;
    logic [NUM_VEC-1:0] cap_q, cap_d;
    logic [NUM_VEC-1:0] mis_q, mis_d;
    logic [NUM_VEC-1:0] exp_q, exp_d;
    logic               pass_q, pass_d;
    logic               tmr_clr, tmr_en, tmr_expired;

    tt_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap_d   = cap_q;
        mis_d   = mis_q;
        exp_d   = exp_q;
        pass_d  = pass_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d   = exp_tt;
                    idx_d   = '0;
                    cap_d   = '0;
                    mis_d   = '0;
                    tmr_clr = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_expired) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                cap_d[idx_q] = y_in;
                mis_d[idx_q] = y_in ^ exp_q[idx_q];
                tmr_clr      = 1'b1;
                if (idx_q == VEC_W'(NUM_VEC - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + VEC_W'(1);
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                pass_d  = (mis_q == '0);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cap_q   <= '0;
            mis_q   <= '0;
            exp_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            mis_q   <= mis_d;
            exp_q   <= exp_d;
            pass_q  <= pass_d;
        end
    end

`ifdef TT_SWEEP_ERRCNT_EN
    logic [3:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == ST_IDLE && start) begin
            err_d = '0;
        end else if (state_q == ST_SAMPLE) begin
            err_d = popcount8(mis_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt = err_q;
`endif

    // The vector index doubles as the registered stimulus, so it holds 7 after a sweep.
    assign {a, b, c} = idx_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign cap_tt    = cap_q;
    assign mismatch  = mis_q;

endmodule
